// File: rtl/gcm_ctr_block_gen.sv
// GCM counter-block generator: emits J0 followed by CB_1..CB_N (inc32 of J0)
// to the AES input over a valid/ready handshake.
module gcm_ctr_block_gen #(
    parameter int NB_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            j0_full,
    input  logic [127:0]    j0_in,
    input  logic [NB_W-1:0] num_blocks,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out_block,
    output logic            out_is_j0,
    output logic [NB_W-1:0] out_idx,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_EMIT_J0  = 2'd1;
    localparam logic [1:0] ST_EMIT_CTR = 2'd2;

    logic [1:0]      state;
    logic [NB_W-1:0] n_lat;
    logic            hs;

    // Only the low 32-bit word counts; the upper 96 bits never see a carry.
    function automatic logic [127:0] inc32(input logic [127:0] blk);
        return {blk[127:32], blk[31:0] + 32'd1};
    endfunction

    function automatic logic [127:0] form_j0(input logic full, input logic [127:0] j0);
        return full ? j0 : {j0[127:32], 32'h0000_0001};
    endfunction

    assign hs = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            n_lat     <= '0;
            out_valid <= 1'b0;
            out_block <= '0;
            out_is_j0 <= 1'b0;
            out_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        out_block <= form_j0(j0_full, j0_in);
                        n_lat     <= num_blocks;
                        out_idx   <= '0;
                        out_is_j0 <= 1'b1;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_EMIT_J0;
                    end
                end
                ST_EMIT_J0: begin
                    if (hs) begin
                        out_is_j0 <= 1'b0;
                        if (n_lat == '0) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            out_block <= inc32(out_block);
                            out_idx   <= {{(NB_W-1){1'b0}}, 1'b1};
                            state     <= ST_EMIT_CTR;
                        end
                    end
                end
                ST_EMIT_CTR: begin
                    // Compare before incrementing so N = 2^NB_W-1 ends without wrapping out_idx.
                    if (hs) begin
                        if (out_idx == n_lat) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end else begin
                            out_block <= inc32(out_block);
                            out_idx   <= out_idx + {{(NB_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
